// File: rtl/multi_slow_clock.sv
// Multi-channel clock divider / tick generator. Each channel produces a registered
// square-wave enable and a one-cycle terminal-count tick in the clkIn domain.
module multi_slow_clock #(
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic                 clkIn,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enable,
  input  logic                 syncAll,
  input  logic                 divLoad,
  input  logic [2:0]           divSel,
  input  logic [CNT_WIDTH-1:0] divValue,
  output logic [NUM_CH-1:0]    clkOut,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    pendingLoad
);

  localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] counter_q, counter_d;
      logic [CNT_WIDTH-1:0] active_q, active_d;
      logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
      logic                 pend_q, pend_d;
      logic                 clk_q, clk_d;
      logic                 tick_q, tick_d;
      logic                 load_hit;

      // Out-of-range divSel never matches any channel, so those loads vanish.
      assign load_hit = divLoad && (divSel == 3'(gi));

      always_comb begin
        counter_d = counter_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        if (syncAll) begin
          counter_d = '0;
          clk_d     = 1'b0;
          // A same-edge load is captured first, then applied with the realignment.
          if (load_hit) begin
            shadow_d = divValue;
            active_d = divValue;
            pend_d   = 1'b0;
          end else if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
          end
        end else if (!enable[gi]) begin
          counter_d = '0;
          if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
          end
          if (load_hit) begin
            shadow_d = divValue;
            pend_d   = 1'b1;
          end
        end else begin
          if (counter_q == active_q) begin
            counter_d = '0;
            tick_d    = 1'b1;
            clk_d     = ~clk_q;
            if (pend_q) begin
              active_d = shadow_q;
              pend_d   = 1'b0;
            end
          end else begin
            counter_d = counter_q + 1'b1;
          end
          // Applied after the terminal so a coincident load waits for the next one.
          if (load_hit) begin
            shadow_d = divValue;
            pend_d   = 1'b1;
          end
        end
      end

      always_ff @(posedge clkIn) begin
        if (reset) begin
          counter_q <= '0;
          active_q  <= DEF_DIV;
          shadow_q  <= DEF_DIV;
          pend_q    <= 1'b0;
          clk_q     <= 1'b0;
          tick_q    <= 1'b0;
        end else begin
          counter_q <= counter_d;
          active_q  <= active_d;
          shadow_q  <= shadow_d;
          pend_q    <= pend_d;
          clk_q     <= clk_d;
          tick_q    <= tick_d;
        end
      end

      assign clkOut[gi]      = clk_q;
      assign tick[gi]        = tick_q;
      assign pendingLoad[gi] = pend_q;
    end
  endgenerate

endmodule
